// File: rtl/kudu_dv_pkg.sv
// Shared types for the OBI testbench agents and the request arbiter.
// Holds the arbiter FSM encoding, the OBI request bundle and size limits.
package kudu_dv_pkg;

   localparam int ARB_MAX_NREQ = 4;
   localparam int OBI_DW       = 32;

   typedef enum logic {
      ARB,
      LOCK
   } arb_state_t;

   typedef struct packed {
      logic              we;
      logic [3:0]        be;
      logic              is_cap;
      logic [3:0]        amo_flag;
      logic [31:0]       addr;
      logic [OBI_DW-1:0] wdata;
      logic [7:0]        flag;
   } obi_req_t;

endpackage

// File: rtl/obi_arb_rsp_fifo.sv
// In-order requester-index FIFO; head read combinationally.
// Ports: push/din, pop/dout, full, empty, count (occupancy).
module obi_arb_rsp_fifo #(
   parameter int DEPTH = 8,
   parameter int IW    = 1
) (
   input  logic                     clk_wr,
   input  logic                     rst_ni,
   input  logic                     push,
   input  logic [IW-1:0]            din,
   input  logic                     pop,
   output logic [IW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [IW-1:0] mem [DEPTH];
   logic [AW:0]   wr_q;
   logic [AW:0]   rd_q;

   // extra MSB on the pointers separates full from empty
   assign count = wr_q - rd_q;
   assign full  = (count == DEPTH_C);
   assign empty = (wr_q == rd_q);
   assign dout  = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk_wr or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_wr) begin
      if (push) mem[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/obi_req_arbiter.sv
// N-to-1 round-robin OBI request arbiter with in-order response routing.
// Ports: m_* requester side, s_* memory side, outstanding, proto_err.
module obi_req_arbiter
   import kudu_dv_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DW    = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk_wr,
   input  logic                   rst_ni,
   input  logic [NREQ-1:0]        m_req,
   input  logic [NREQ-1:0]        m_we,
   input  logic [NREQ-1:0][3:0]   m_be,
   input  logic [NREQ-1:0]        m_is_cap,
   input  logic [NREQ-1:0][3:0]   m_amo_flag,
   input  logic [NREQ-1:0][31:0]  m_addr,
   input  logic [NREQ-1:0][DW-1:0] m_wdata,
   input  logic [NREQ-1:0][7:0]   m_flag,
   output logic [NREQ-1:0]        m_gnt,
   output logic [NREQ-1:0]        m_rvalid,
   output logic [DW-1:0]          m_rdata,
   output logic [NREQ-1:0]        m_err,
   output logic [NREQ-1:0]        m_sc_resp,
   output logic                   s_req,
   output logic                   s_we,
   output logic [3:0]             s_be,
   output logic                   s_is_cap,
   output logic [3:0]             s_amo_flag,
   output logic [31:0]            s_addr,
   output logic [DW-1:0]          s_wdata,
   output logic [7:0]             s_flag,
   input  logic                   s_gnt,
   input  logic                   s_rvalid,
   input  logic [DW-1:0]          s_rdata,
   input  logic                   s_err,
   input  logic                   s_sc_resp,
   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   proto_err
);

   localparam int IW = $clog2(NREQ);

   arb_state_t    state_q;
   logic [IW-1:0] sel_q;
   logic [IW-1:0] rr_q;
   logic [IW-1:0] win;
   logic [IW-1:0] cur;
   logic [IW-1:0] rr_nxt;
   logic [IW-1:0] head;
   logic          win_vld;
   logic          full;
   logic          empty;
   logic          gnt;
   logic          pop;
   logic          lock_bad;
   obi_req_t      req [NREQ];
   obi_req_t      cur_req;
   obi_req_t      snap_q;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req[i] = '{
            we:       m_we[i],
            be:       m_be[i],
            is_cap:   m_is_cap[i],
            amo_flag: m_amo_flag[i],
            addr:     m_addr[i],
            wdata:    OBI_DW'(m_wdata[i]),
            flag:     m_flag[i]
         };
      end
   end

   // descending scan so the requester closest to rr_q wins
   always_comb begin
      int idx;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (m_req[idx]) begin
            win     = IW'(idx);
            win_vld = 1'b1;
         end
      end
   end

   assign cur     = (state_q == LOCK) ? sel_q : win;
   assign cur_req = req[cur];
   assign rr_nxt  = IW'((int'(cur) + 1) % NREQ);

   // a locked request is never withdrawn, even when full
   assign s_req = rst_ni & ((state_q == LOCK) | (win_vld & ~full));
   assign gnt   = s_gnt & s_req;
   assign pop   = rst_ni & s_rvalid & ~empty;

   assign s_we       = cur_req.we;
   assign s_be       = cur_req.be;
   assign s_is_cap   = cur_req.is_cap;
   assign s_amo_flag = cur_req.amo_flag;
   assign s_addr     = cur_req.addr;
   assign s_wdata    = m_wdata[cur];
   assign s_flag     = cur_req.flag;

   assign m_gnt     = gnt ? (NREQ'(1) << cur) : '0;
   assign m_rvalid  = pop ? (NREQ'(1) << head) : '0;
   assign m_err     = (pop & s_err) ? (NREQ'(1) << head) : '0;
   assign m_sc_resp = (pop & s_sc_resp) ? (NREQ'(1) << head) : '0;
   assign m_rdata   = s_rdata;

   assign lock_bad = (state_q == LOCK) &
                     (~m_req[sel_q] | (req[sel_q] != snap_q));

   obi_arb_rsp_fifo #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_fifo (
      .clk_wr (clk_wr),
      .rst_ni (rst_ni),
      .push   (gnt),
      .din    (cur),
      .pop    (pop),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .count  (outstanding)
   );

   always_ff @(posedge clk_wr or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ARB;
         sel_q     <= '0;
         rr_q      <= '0;
         snap_q    <= '0;
         proto_err <= 1'b0;
      end else begin
         unique case (state_q)
            ARB: begin
               if (s_req && !s_gnt) begin
                  state_q <= LOCK;
                  sel_q   <= win;
                  snap_q  <= cur_req;
               end
            end
            LOCK: begin
               if (s_gnt) state_q <= ARB;
            end
            default: state_q <= ARB;
         endcase
         if (gnt) rr_q <= rr_nxt;
         if ((s_rvalid && empty) || lock_bad) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_obi_req_arbiter.sv
// Directed bench for obi_req_arbiter (NREQ=2, DEPTH=8).
// The bench plays the memory side by driving s_gnt / s_rvalid directly.
module tb_obi_req_arbiter;

   localparam int NREQ  = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic                   clk_wr = 1'b0;
   logic                   rst_ni;
   logic [NREQ-1:0]        m_req;
   logic [NREQ-1:0]        m_we;
   logic [NREQ-1:0][3:0]   m_be;
   logic [NREQ-1:0]        m_is_cap;
   logic [NREQ-1:0][3:0]   m_amo_flag;
   logic [NREQ-1:0][31:0]  m_addr;
   logic [NREQ-1:0][DW-1:0] m_wdata;
   logic [NREQ-1:0][7:0]   m_flag;
   logic [NREQ-1:0]        m_gnt;
   logic [NREQ-1:0]        m_rvalid;
   logic [DW-1:0]          m_rdata;
   logic [NREQ-1:0]        m_err;
   logic [NREQ-1:0]        m_sc_resp;
   logic                   s_req;
   logic                   s_we;
   logic [3:0]             s_be;
   logic                   s_is_cap;
   logic [3:0]             s_amo_flag;
   logic [31:0]            s_addr;
   logic [DW-1:0]          s_wdata;
   logic [7:0]             s_flag;
   logic                   s_gnt;
   logic                   s_rvalid;
   logic [DW-1:0]          s_rdata;
   logic                   s_err;
   logic                   s_sc_resp;
   logic [3:0]             outstanding;
   logic                   proto_err;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk_wr = ~clk_wr;

   obi_req_arbiter #(
      .NREQ  (NREQ),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk_wr      (clk_wr),
      .rst_ni      (rst_ni),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_be        (m_be),
      .m_is_cap    (m_is_cap),
      .m_amo_flag  (m_amo_flag),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_flag      (m_flag),
      .m_gnt       (m_gnt),
      .m_rvalid    (m_rvalid),
      .m_rdata     (m_rdata),
      .m_err       (m_err),
      .m_sc_resp   (m_sc_resp),
      .s_req       (s_req),
      .s_we        (s_we),
      .s_be        (s_be),
      .s_is_cap    (s_is_cap),
      .s_amo_flag  (s_amo_flag),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_flag      (s_flag),
      .s_gnt       (s_gnt),
      .s_rvalid    (s_rvalid),
      .s_rdata     (s_rdata),
      .s_err       (s_err),
      .s_sc_resp   (s_sc_resp),
      .outstanding (outstanding),
      .proto_err   (proto_err)
   );

   // inputs change at posedge+1, checks happen at the negedge
   task automatic tick();
      @(posedge clk_wr);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1;
      #2;
      n_run++;
      if (m_gnt !== 2'b00 || m_rvalid !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_out gnt=%b rv=%b exp 00/00", m_gnt, m_rvalid);
      end
      n_run++;
      if (outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_state out=%0d perr=%b exp 0/0",
                  outstanding, proto_err);
      end
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      logic [1:0] exp_r;
      for (int c = 0; c <= 16; c++) begin
         m_req    = (c < 16) ? 2'b11 : 2'b00;
         s_gnt    = (c < 16);
         s_rvalid = (c > 0);
         s_rdata  = 32'hA000 + c;
         exp_g    = (c == 16) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
         exp_r    = (c == 0) ? 2'b00 : (((c-1) % 2 == 0) ? 2'b01 : 2'b10);
         #4;
         n_run++;
         if (m_gnt !== exp_g) begin
            n_fail++;
            $display("FAIL b2b_gnt c=%0d got %b exp %b", c, m_gnt, exp_g);
         end
         n_run++;
         if (m_rvalid !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_rv c=%0d got %b exp %b", c, m_rvalid, exp_r);
         end
         if (c > 0) begin
            n_run++;
            if (outstanding !== 4'd1 || m_rdata !== 32'hA000 + c) begin
               n_fail++;
               $display("FAIL b2b_occ c=%0d out=%0d rd=%h exp 1/%h",
                        c, outstanding, m_rdata, 32'hA000 + c);
            end
         end
         tick();
      end
      s_rvalid = 1'b0;
      #4;
      n_run++;
      if (outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end out=%0d perr=%b exp 0/0",
                  outstanding, proto_err);
      end
      tick();
   endtask

   task automatic test_lock();
      m_req = 2'b10; s_gnt = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) m_req = 2'b11;
         #4;
         n_run++;
         if (s_req !== 1'b1 || s_addr !== 32'h2000 || m_gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_hold c=%0d req=%b addr=%h gnt=%b exp 1/2000/00",
                     c, s_req, s_addr, m_gnt);
         end
         tick();
      end
      s_gnt = 1'b1;
      #4;
      n_run++;
      if (m_gnt !== 2'b10 || s_addr !== 32'h2000) begin
         n_fail++;
         $display("FAIL lock_gnt1 gnt=%b addr=%h exp 10/2000", m_gnt, s_addr);
      end
      tick();
      m_req = 2'b01;
      #4;
      n_run++;
      if (m_gnt !== 2'b01 || s_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL lock_gnt0 gnt=%b addr=%h exp 01/1000", m_gnt, s_addr);
      end
      tick();
      m_req = 2'b00; s_gnt = 1'b0;
      s_rvalid = 1'b1; s_err = 1'b1; s_sc_resp = 1'b0;
      #4;
      n_run++;
      if (m_rvalid !== 2'b10 || m_err !== 2'b10 || m_sc_resp !== 2'b00) begin
         n_fail++;
         $display("FAIL lock_rsp1 rv=%b err=%b sc=%b exp 10/10/00",
                  m_rvalid, m_err, m_sc_resp);
      end
      tick();
      s_err = 1'b0; s_sc_resp = 1'b1;
      #4;
      n_run++;
      if (m_rvalid !== 2'b01 || m_err !== 2'b00 || m_sc_resp !== 2'b01) begin
         n_fail++;
         $display("FAIL lock_rsp0 rv=%b err=%b sc=%b exp 01/00/01",
                  m_rvalid, m_err, m_sc_resp);
      end
      tick();
      s_rvalid = 1'b0; s_sc_resp = 1'b0;
      #4;
      n_run++;
      if (outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_end out=%0d perr=%b exp 0/0",
                  outstanding, proto_err);
      end
      tick();
   endtask

   task automatic test_fifo_full();
      m_req = 2'b01; s_gnt = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #4;
         n_run++;
         if (m_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL full_fill c=%0d gnt=%b exp 01", c, m_gnt);
         end
         tick();
      end
      s_rvalid = 1'b1;
      #4;
      n_run++;
      if (outstanding !== 4'd8 || s_req !== 1'b0 || m_gnt !== 2'b00) begin
         n_fail++;
         $display("FAIL full_block out=%0d sreq=%b gnt=%b exp 8/0/00",
                  outstanding, s_req, m_gnt);
      end
      n_run++;
      if (m_rvalid !== 2'b01) begin
         n_fail++;
         $display("FAIL full_pop rv=%b exp 01", m_rvalid);
      end
      tick();
      #4;
      n_run++;
      if (outstanding !== 4'd7 || m_gnt !== 2'b01 || m_rvalid !== 2'b01) begin
         n_fail++;
         $display("FAIL full_next out=%0d gnt=%b rv=%b exp 7/01/01",
                  outstanding, m_gnt, m_rvalid);
      end
      tick();
      m_req = 2'b00; s_gnt = 1'b0;
      #4;
      n_run++;
      if (outstanding !== 4'd7) begin
         n_fail++;
         $display("FAIL full_pp out=%0d exp 7", outstanding);
      end
      for (int c = 0; c < 7; c++) tick();
      s_rvalid = 1'b0;
      #4;
      n_run++;
      if (outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drain out=%0d perr=%b exp 0/0",
                  outstanding, proto_err);
      end
      tick();
   endtask

   task automatic test_push_pop();
      m_req = 2'b01; s_gnt = 1'b1;
      tick();
      m_req = 2'b10; s_rvalid = 1'b1;
      #4;
      n_run++;
      if (m_gnt !== 2'b10 || m_rvalid !== 2'b01 || outstanding !== 4'd1) begin
         n_fail++;
         $display("FAIL pp_same gnt=%b rv=%b out=%0d exp 10/01/1",
                  m_gnt, m_rvalid, outstanding);
      end
      tick();
      m_req = 2'b00; s_gnt = 1'b0;
      #4;
      n_run++;
      if (outstanding !== 4'd1 || m_rvalid !== 2'b10) begin
         n_fail++;
         $display("FAIL pp_after out=%0d rv=%b exp 1/10", outstanding, m_rvalid);
      end
      tick();
      s_rvalid = 1'b0;
   endtask

   task automatic test_spurious();
      s_rvalid = 1'b1;
      #4;
      n_run++;
      if (m_rvalid !== 2'b00 || outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL spur_route rv=%b out=%0d perr=%b exp 00/0/0",
                  m_rvalid, outstanding, proto_err);
      end
      tick();
      s_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #4;
         n_run++;
         if (proto_err !== 1'b1 || outstanding !== 4'd0) begin
            n_fail++;
            $display("FAIL spur_sticky c=%0d perr=%b out=%0d exp 1/0",
                     c, proto_err, outstanding);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      m_req = 2'b01; s_gnt = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      m_req = 2'b10; s_gnt = 1'b0;
      tick();
      #4;
      n_run++;
      if (outstanding !== 4'd3 || s_req !== 1'b1 || s_addr !== 32'h2000) begin
         n_fail++;
         $display("FAIL rmid_pre out=%0d sreq=%b addr=%h exp 3/1/2000",
                  outstanding, s_req, s_addr);
      end
      s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b1; s_sc_resp = 1'b1;
      rst_ni = 1'b0;
      #1;
      n_run++;
      if (m_gnt !== 2'b00 || m_rvalid !== 2'b00 ||
          m_err !== 2'b00 || m_sc_resp !== 2'b00) begin
         n_fail++;
         $display("FAIL rmid_out gnt=%b rv=%b err=%b sc=%b exp all 00",
                  m_gnt, m_rvalid, m_err, m_sc_resp);
      end
      n_run++;
      if (outstanding !== 4'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_state out=%0d perr=%b exp 0/0",
                  outstanding, proto_err);
      end
      tick();
      s_rvalid = 1'b0; s_err = 1'b0; s_sc_resp = 1'b0;
      m_req = 2'b11;
      rst_ni = 1'b1;
      #4;
      n_run++;
      if (m_gnt !== 2'b01 || s_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL rmid_arb gnt=%b addr=%h exp 01/1000", m_gnt, s_addr);
      end
      tick();
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
      #4;
      n_run++;
      if (m_rvalid !== 2'b01 || outstanding !== 4'd1 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_rsp rv=%b out=%0d perr=%b exp 01/1/0",
                  m_rvalid, outstanding, proto_err);
      end
      tick();
      s_rvalid = 1'b0;
   endtask

   initial begin
      m_req      = '0;
      m_we       = 2'b10;
      m_be       = {4'hC, 4'h3};
      m_is_cap   = 2'b01;
      m_amo_flag = {4'h5, 4'hA};
      m_addr     = {32'h2000, 32'h1000};
      m_wdata    = {32'hBBBB_0001, 32'hAAAA_0000};
      m_flag     = {8'h22, 8'h11};
      s_gnt      = 1'b0;
      s_rvalid   = 1'b0;
      s_rdata    = '0;
      s_err      = 1'b0;
      s_sc_resp  = 1'b0;
      test_reset();
      test_back_to_back();
      test_lock();
      test_fifo_full();
      test_push_pop();
      test_spurious();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
